vga_framebuffer: RTL and testbench
==================================

// Module: vga_framebuffer
// PURPOSE
//  Pixel source that sits directly upstream of the VGA timing generator's colour inputs.
//  - Holds a 160x120 low-resolution, 3-bit RGB bitmap.
//  - Each stored pixel is shown as a 4x4 block on the 640x480 @ 25.175 MHz raster.
//  - Display side: takes hcount/vcount/hSync/vSync from the timing generator and returns
//    colour plus syncs, all delayed by the same fixed pipeline.
//  - Write side: accepts pixel writes from the CPU/bus with a valid/ready handshake.
//  - Contains a hardware clear engine.
// PARAMETERS
//  H_VIS_START  144    first visible hcount (96 sync + 48 back porch)
//  V_VIS_START  35     first visible vcount (2 sync + 33 back porch)
//  FB_W         160    framebuffer columns
//  FB_H         120    framebuffer rows
//  BG_COLOUR    3'b000 value written by the clear engine, {r,g,b}
// PORTS
//  clk25175KHz  in   1   pixel clock, only clock in the block
//  reset        in   1   synchronous, active-low (0 = reset)
//  hcount       in   10  horizontal counter from timing generator, 0..799
//  vcount       in   10  vertical counter from timing generator, 0..524
//  hSyncIn      in   1   hSync from timing generator
//  vSyncIn      in   1   vSync from timing generator
//  redOut       out  1   pixel red, aligned with hSyncOut/vSyncOut
//  greenOut     out  1   pixel green
//  blueOut      out  1   pixel blue
//  hSyncOut     out  1   hSyncIn delayed 2 cycles
//  vSyncOut     out  1   vSyncIn delayed 2 cycles
//  wrValid      in   1   write request
//  wrReady      out  1   write can be accepted
//  wrAddr       in   15  linear pixel address, row*160+col
//  wrData       in   3   {r,g,b}
//  clearReq     in   1   one-cycle pulse: fill framebuffer with BG_COLOUR
//  busy         out  1   clear engine running
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - All outputs are 0: rgb, syncs, wrReady, busy.
//   - The pipeline is flushed.
//   - Framebuffer contents are undefined.
//  First edge with reset==1: the clear engine starts automatically.
//  Display pipeline, latency exactly 2 cycles:
//   - S0, on the edge after (hcount,vcount) is presented:
//       active = (H_VIS_START <= hcount < H_VIS_START+640) && (V_VIS_START <= vcount < V_VIS_START+480)
//       col    = (hcount-H_VIS_START)>>2
//       row    = (vcount-V_VIS_START)>>2
//       addr   = (row<<7)+(row<<5)+col   (shift/add only, no multiplier)
//     Register addr and active; syncs go through a matching 2-stage shift register.
//   - S1: RAM read is registered.
//       rgb = active_d2 ? ram_q : 3'b000   (AND gate after the registers)
//   - Blanking therefore always outputs 0.
//  Write port:
//   - A transfer occurs on an edge where wrValid && wrReady.
//   - wrReady = !busy && reset, so it is 0 while clearing.
//   - Transfers with wrAddr >= 19200 are accepted and discarded.
//   - A write is visible to the display from the read cycle after the write edge.
//     Read-during-write to the same address returns old data.
//  Clear FSM states:
//   - IDLE -> CLEAR on the first edge out of reset, or on clearReq in IDLE.
//   - CLEAR writes BG_COLOUR to addr 0..19199, one address per cycle.
//   - CLEAR -> IDLE after addr 19199 is written. busy is 1 for exactly 19200 cycles.
//   - clearReq during CLEAR is ignored; the sweep is not restarted.
//   - clearReq and wrValid in the same IDLE cycle: the write is accepted, then the clear starts.
//   - Reset mid-clear aborts the sweep; the full clear restarts from addr 0 after release.
//  The display pipeline runs unaffected during CLEAR.
// STRUCTURE
//  vga_pkg:
//   - H_VIS_START, V_VIS_START, H_TOTAL=800, V_TOTAL=525, FB_W, FB_H
//   - FB_DEPTH=19200, FB_AW=15
//   - clear FSM state encoding
//  Sub-module fb_ram_dp: simple dual-port 3x19200 RAM.
//   - One synchronous write port, one registered read port.
//   - Single clock; infers block RAM.
//  Top level: address pipeline, sync delay line, clear FSM, write-port mux (clear vs bus).
// TESTING
//  1 Release reset, wrValid=1 held -> wrReady=0 and busy=1 for exactly 19200 cycles,
//    then wrReady=1; full frame shows rgb=BG_COLOUR in visible area.
//  2 Write addr 0 <- 3'b101 -> rgb=101 exactly 2 cycles after each (h,v) in h 144..147, v 35..38;
//    h=148 -> BG_COLOUR.
//  3 Write addr 19199 <- 3'b111 -> rgb=111 for h 780..783, v 511..514 only.
//    Write addr 19200 <- 111 -> accepted, no visible change.
//  4 Fill framebuffer with 111; sweep all (h,v):
//    - rgb=000 whenever h<144, h>=784, v<35 or v>=515.
//    - hSyncOut/vSyncOut equal hSyncIn/vSyncIn delayed 2 cycles.
//  5 clearReq mid-frame with wrValid=1 -> write stalls (wrReady=0) for 19200 cycles.
//    A second clearReq 100 cycles in does not extend busy.
//  6 Assert reset 5000 cycles into a clear, release -> busy=1 for a full 19200 cycles,
//    all outputs 0 during reset.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, clear-FSM state encoding and the framebuffer
// address helper for the low-resolution VGA framebuffer.
package vga_pkg;

    localparam int unsigned H_VIS_START = 144;
    localparam int unsigned V_VIS_START = 35;
    localparam int unsigned H_VIS       = 640;
    localparam int unsigned V_VIS       = 480;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned FB_W        = 160;
    localparam int unsigned FB_H        = 120;
    localparam int unsigned FB_DEPTH    = FB_W * FB_H;
    localparam int unsigned FB_AW       = 15;
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned RGB_W       = 3;
    localparam int unsigned ROW_W       = 7;
    localparam int unsigned COL_W       = 8;

    localparam logic [RGB_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        CLR_INIT  = 2'd0,
        CLR_IDLE  = 2'd1,
        CLR_CLEAR = 2'd2
    } clr_state_e;

    // row*160 + col built from shifts and adds only
    function automatic logic [FB_AW-1:0] fb_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        return FB_AW'({row, 7'b0}) + FB_AW'({row, 5'b0}) + FB_AW'(col);
    endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// fb_ram_dp: simple dual-port RAM, one synchronous write port and one
// registered read port on a single clock. Read-during-write returns old data.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr in, rd_data out (1 cycle).
module fb_ram_dp #(
    parameter int unsigned DEPTH = 19200,
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120 3-bit RGB bitmap shown as 4x4 blocks on a 640x480
// raster, with a bus write port and a hardware clear engine.
// Ports: clk25175KHz, reset (sync, active-low); hcount/vcount/hSyncIn/vSyncIn
// from the timing generator; redOut/greenOut/blueOut/hSyncOut/vSyncOut delayed
// 2 cycles; wrValid/wrReady/wrAddr/wrData write handshake; clearReq pulse, busy.
module vga_framebuffer
    import vga_pkg::*;
(
    input  logic              clk25175KHz,
    input  logic              reset,
    input  logic [CNT_W-1:0]  hcount,
    input  logic [CNT_W-1:0]  vcount,
    input  logic              hSyncIn,
    input  logic              vSyncIn,
    output logic              redOut,
    output logic              greenOut,
    output logic              blueOut,
    output logic              hSyncOut,
    output logic              vSyncOut,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [FB_AW-1:0]  wrAddr,
    input  logic [RGB_W-1:0]  wrData,
    input  logic              clearReq,
    output logic              busy
);

    // ---------------- display pipeline ----------------
    logic [CNT_W-1:0] h_off_c, v_off_c;
    logic             active_c;
    logic [FB_AW-1:0] rd_addr_d, rd_addr_q;
    logic             act0_d, act0_q, act1_d, act1_q;
    logic [1:0]       hs_d, hs_q, vs_d, vs_q;
    logic [RGB_W-1:0] ram_rd_c;

    // S0 address generation; out-of-window positions read address 0
    always_comb begin
        h_off_c  = hcount - CNT_W'(H_VIS_START);
        v_off_c  = vcount - CNT_W'(V_VIS_START);
        active_c = (hcount >= CNT_W'(H_VIS_START)) && (hcount < CNT_W'(H_VIS_START + H_VIS)) &&
                   (vcount >= CNT_W'(V_VIS_START)) && (vcount < CNT_W'(V_VIS_START + V_VIS));
        rd_addr_d = '0;
        if (active_c) begin
            rd_addr_d = fb_addr(ROW_W'(v_off_c >> 2), COL_W'(h_off_c >> 2));
        end
        act0_d = active_c;
        act1_d = act0_q;
        hs_d   = {hs_q[0], hSyncIn};
        vs_d   = {vs_q[0], vSyncIn};
    end

    always_ff @(posedge clk25175KHz) begin
        if (!reset) begin
            rd_addr_q <= '0;
            act0_q    <= 1'b0;
            act1_q    <= 1'b0;
            hs_q      <= '0;
            vs_q      <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            act0_q    <= act0_d;
            act1_q    <= act1_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    // blanking gate sits after the RAM output register
    assign {redOut, greenOut, blueOut} = act1_q ? ram_rd_c : RGB_W'(0);
    assign hSyncOut = hs_q[1];
    assign vSyncOut = vs_q[1];

    // ---------------- clear FSM ----------------
    clr_state_e       state_d, state_q;
    logic [FB_AW-1:0] clr_addr_d, clr_addr_q;
    logic             busy_d, busy_q, wr_ready_d, wr_ready_q;
    logic             ram_we_c;
    logic [FB_AW-1:0] ram_wa_c;
    logic [RGB_W-1:0] ram_wd_c;

    // state register; CLR_INIT makes the first edge out of reset start a sweep
    always_ff @(posedge clk25175KHz) begin
        if (!reset) begin
            state_q    <= CLR_INIT;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // next state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLR_INIT: begin
                state_d    = CLR_CLEAR;
                clr_addr_d = '0;
            end
            CLR_IDLE: begin
                if (clearReq) begin
                    state_d    = CLR_CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLR_CLEAR: begin
                clr_addr_d = clr_addr_q + FB_AW'(1);
                if (clr_addr_q == FB_AW'(FB_DEPTH - 1)) begin
                    state_d    = CLR_IDLE;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLR_INIT;
        endcase
    end

    // outputs and RAM write mux (clear sweep has priority over the bus)
    always_comb begin
        busy_d     = (state_d == CLR_CLEAR);
        wr_ready_d = (state_d == CLR_IDLE);
        ram_we_c   = 1'b0;
        ram_wa_c   = '0;
        ram_wd_c   = '0;
        if (state_q == CLR_CLEAR) begin
            ram_we_c = 1'b1;
            ram_wa_c = clr_addr_q;
            ram_wd_c = BG_COLOUR;
        end else if (wrValid && wr_ready_q && (wrAddr < FB_AW'(FB_DEPTH))) begin
            ram_we_c = 1'b1;
            ram_wa_c = wrAddr;
            ram_wd_c = wrData;
        end
    end

    assign busy    = busy_q;
    assign wrReady = wr_ready_q;

    fb_ram_dp #(
        .DEPTH (FB_DEPTH),
        .AW    (FB_AW),
        .DW    (RGB_W)
    ) u_ram (
        .clk     (clk25175KHz),
        .we      (ram_we_c),
        .wr_addr (ram_wa_c),
        .wr_data (ram_wd_c),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rd_c)
    );

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: directed vectors; expected values go into a scoreboard
// tagged with the cycle they are due, and a monitor on the falling edge checks them.
module tb_vga_framebuffer;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        hSyncIn, vSyncIn;
    logic        redOut, greenOut, blueOut, hSyncOut, vSyncOut;
    logic        wrValid, wrReady;
    logic [14:0] wrAddr;
    logic [2:0]  wrData;
    logic        clearReq, busy;

    always #20 clk = ~clk;

    vga_framebuffer dut (
        .clk25175KHz (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .hSyncIn     (hSyncIn),
        .vSyncIn     (vSyncIn),
        .redOut      (redOut),
        .greenOut    (greenOut),
        .blueOut     (blueOut),
        .hSyncOut    (hSyncOut),
        .vSyncOut    (vSyncOut),
        .wrValid     (wrValid),
        .wrReady     (wrReady),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .clearReq    (clearReq),
        .busy        (busy)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected {r,g,b,hSyncOut,vSyncOut,busy,wrReady} under mask, due at cycle
    typedef struct {
        int unsigned due;
        logic [6:0]  mask;
        logic [6:0]  exp;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] got;

    always @(negedge clk) begin
        got = {redOut, greenOut, blueOut, hSyncOut, vSyncOut, busy, wrReady};
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                vectors++;
                if ((got & sb[i].mask) !== sb[i].exp) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
                             sb[i].tag, cyc, got & sb[i].mask, sb[i].exp, sb[i].mask);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s slot %0d missed at cyc=%0d", sb[i].tag, sb[i].due, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pix(input logic [2:0] rgb, input string tag);
        sb.push_back('{cyc + 2, 7'b1111100, {rgb, hSyncIn, vSyncIn, 2'b00}, tag});
    endtask

    task automatic pix(input int h, input int v, input logic hs, input logic vs,
                       input logic [2:0] rgb, input string tag);
        hcount  = 10'(h);
        vcount  = 10'(v);
        hSyncIn = hs;
        vSyncIn = vs;
        exp_pix(rgb, tag);
        tick();
    endtask

    task automatic stat(input logic b, input logic r, input string tag);
        sb.push_back('{cyc, 7'b0000011, {5'b00000, b, r}, tag});
    endtask

    task automatic all_zero(input string tag);
        sb.push_back('{cyc, 7'b1111111, 7'b0000000, tag});
    endtask

    task automatic wr(input int a, input logic [2:0] d);
        wrValid = 1'b1;
        wrAddr  = 15'(a);
        wrData  = d;
        stat(1'b0, 1'b1, "wr_ready_idle");
        tick();
        wrValid = 1'b0;
    endtask

    // called just after the edge that starts a sweep; ends on the edge that
    // first shows busy=0, with a stray clearReq and a display probe inside
    task automatic expect_clear(input string tag);
        stat(1'b1, 1'b0, {tag, "_first"});
        for (int k = 1; k < 19200; k++) begin
            tick();
            clearReq = (k == 100);
            if (k == 300) begin
                hcount  = 10'd144;
                vcount  = 10'd35;
                hSyncIn = 1'b1;
                vSyncIn = 1'b0;
                exp_pix(3'b000, {tag, "_display_during_clear"});
            end else begin
                hSyncIn = 1'b0;
            end
            if (k == 9600 || k == 19199) stat(1'b1, 1'b0, {tag, "_busy"});
        end
        tick();
        stat(1'b0, 1'b1, {tag, "_done"});
    endtask

    function automatic logic [2:0] exp_row(input int h, input bit row0);
        if ((h >= 144 && h <= 147) || (h >= 780 && h <= 783)) return 3'b111;
        if (row0 && h >= 152 && h <= 155) return 3'b011;
        return 3'b000;
    endfunction

    initial begin
        reset = 1'b0; hcount = 10'd200; vcount = 10'd100;
        hSyncIn = 1'b1; vSyncIn = 1'b1;
        wrValid = 1'b0; wrAddr = '0; wrData = '0; clearReq = 1'b0;

        // reset and automatic clear, write held off the whole time
        tick(); tick();
        all_zero("reset_outputs");
        tick();
        reset = 1'b1; hSyncIn = 1'b0; vSyncIn = 1'b0;
        wrValid = 1'b1; wrAddr = 15'd19200; wrData = 3'b111;
        tick();
        expect_clear("init_clear");
        tick();
        wrValid = 1'b0;
        pix(144, 35, 1'b0, 1'b0, BG_COLOUR, "bg_top_left");
        pix(783, 514, 1'b1, 1'b1, BG_COLOUR, "bg_bottom_right");
        pix(400, 275, 1'b0, 1'b1, BG_COLOUR, "bg_middle");

        // pixel 0 covers h 144..147, v 35..38
        wr(0, 3'b101);
        for (int v = 35; v <= 38; v++)
            for (int h = 144; h <= 147; h++)
                pix(h, v, 1'(h), 1'(v), 3'b101, "addr0_block");
        pix(148, 35, 1'b0, 1'b1, BG_COLOUR, "addr0_right_edge");
        pix(144, 39, 1'b1, 1'b0, BG_COLOUR, "addr0_below");

        // read and write of address 2 on the same edge returns old data
        hcount = 10'd152; vcount = 10'd35;
        exp_pix(3'b000, "rdw_old");
        tick();
        wrValid = 1'b1; wrAddr = 15'd2; wrData = 3'b011;
        exp_pix(3'b011, "rdw_new");
        tick();
        wrValid = 1'b0;

        // last pixel and out-of-range write
        wr(19199, 3'b111);
        pix(780, 511, 1'b1, 1'b0, 3'b111, "last_tl");
        pix(783, 514, 1'b0, 1'b1, 3'b111, "last_br");
        pix(779, 511, 1'b0, 1'b0, BG_COLOUR, "last_left");
        pix(780, 510, 1'b1, 1'b1, BG_COLOUR, "last_above");
        pix(784, 514, 1'b0, 1'b0, 3'b000, "blank_h784");
        pix(783, 515, 1'b1, 1'b0, 3'b000, "blank_v515");
        wr(19200, 3'b111);
        pix(144, 35, 1'b0, 1'b0, 3'b101, "oob_no_change_0");
        pix(783, 514, 1'b0, 1'b0, 3'b111, "oob_no_change_last");

        // corner pixels, then row and column sweeps across blanking
        wr(0, 3'b111);
        wr(159, 3'b111);
        wr(19040, 3'b111);
        for (int h = 0; h < int'(H_TOTAL); h++)
            pix(h, 35, h < 96, 1'(h >> 3), exp_row(h, 1'b1), "sweep_v35");
        for (int h = 0; h < int'(H_TOTAL); h++)
            pix(h, 514, 1'(h >> 2), h < 96, exp_row(h, 1'b0), "sweep_v514");
        for (int h = 0; h < int'(H_TOTAL); h++)
            pix(h, 515, h < 96, 1'(h), 3'b000, "sweep_v515");
        for (int v = 0; v < int'(V_TOTAL); v++)
            pix(144, v, 1'(v >> 2), v < 2,
                ((v >= 35 && v <= 38) || (v >= 511 && v <= 514)) ? 3'b111 : 3'b000,
                "sweep_h144");

        // clearReq together with a write: write taken, then sweep, write stalls
        wrValid = 1'b1; wrAddr = 15'd5; wrData = 3'b111; clearReq = 1'b1;
        stat(1'b0, 1'b1, "clr_req_ready");
        tick();
        clearReq = 1'b0; wrData = 3'b010;
        expect_clear("req_clear");
        tick();
        wrValid = 1'b0;
        pix(164, 35, 1'b0, 1'b0, 3'b010, "post_clear_write");
        pix(160, 35, 1'b0, 1'b0, BG_COLOUR, "post_clear_col4");
        pix(144, 35, 1'b0, 1'b0, BG_COLOUR, "post_clear_col0");

        // reset 5000 cycles into a sweep, then a full sweep again
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        stat(1'b1, 1'b0, "abort_start");
        for (int k = 0; k < 5000; k++) tick();
        reset = 1'b0; hSyncIn = 1'b1; vSyncIn = 1'b1;
        hcount = 10'd144; vcount = 10'd35;
        wrValid = 1'b1; wrAddr = 15'd0; wrData = 3'b110;
        tick();
        all_zero("abort_reset_a");
        tick();
        all_zero("abort_reset_b");
        tick();
        reset = 1'b1; hSyncIn = 1'b0; vSyncIn = 1'b0;
        tick();
        expect_clear("restart_clear");
        tick();
        wrValid = 1'b0;
        pix(144, 35, 1'b1, 1'b1, 3'b110, "restart_write");
        pix(148, 35, 1'b0, 1'b0, BG_COLOUR, "restart_bg");

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d checks never reached", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
